// File: rtl/baud_frac_gen_pkg.sv
// rtl/baud_frac_gen_pkg.sv - shared UART timing constants and helpers
package baud_frac_gen_pkg;

    localparam int UART_OVS        = 16;
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_STOP_BITS  = 1;

    // Divisor pairs are clk / baud / OVS, split into integer and 1/16 parts
    localparam int B19200_100M_DIV  = 325;
    localparam int B19200_100M_FRAC = 8;
    localparam int B115200_100M_DIV  = 54;
    localparam int B115200_100M_FRAC = 4;
    localparam int B9600_50M_DIV    = 325;
    localparam int B9600_50M_FRAC   = 8;

    function automatic int ovs_width(input int ovs);
        return (ovs < 2) ? 1 : $clog2(ovs);
    endfunction

endpackage

// File: rtl/baud_frac_gen_if.sv
// rtl/baud_frac_gen_if.sv - control and tick signals of the fractional baud generator
interface baud_frac_gen_if
    import baud_frac_gen_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4,
    parameter int OVS    = UART_OVS
) ();
    localparam int OVS_W = ovs_width(OVS);

    logic              en;
    logic              resync;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              div_ack;
    logic              s_tick;
    logic              bit_tick;
    logic [DIV_W-1:0]  q;
    logic [OVS_W-1:0]  ovs_q;

    modport master (
        output en, resync, div_int, div_frac, div_load,
        input  div_ack, s_tick, bit_tick, q, ovs_q
    );

    modport slave (
        input  en, resync, div_int, div_frac, div_load,
        output div_ack, s_tick, bit_tick, q, ovs_q
    );
endinterface

// File: rtl/baud_ovs_counter.sv
// rtl/baud_ovs_counter.sv - modulo-OVS oversample phase counter
module baud_ovs_counter
    import baud_frac_gen_pkg::*;
#(
    parameter int OVS = UART_OVS,
    localparam int W  = ovs_width(OVS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic         wrap,
    output logic [W-1:0] phase
);

    assign wrap = inc & (phase == W'(OVS - 1));

    // OVS is a power of two, so the natural rollover is the modulo wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= '0;
        end else if (clear) begin
            phase <= '0;
        end else if (inc) begin
            phase <= phase + W'(1);
        end
    end

endmodule

// File: rtl/baud_frac_gen.sv
// rtl/baud_frac_gen.sv - fractional-N baud tick generator with shadowed divisor
module baud_frac_gen
    import baud_frac_gen_pkg::*;
#(
    parameter int DIV_W    = 16,
    parameter int FRAC_W   = 4,
    parameter int OVS      = UART_OVS,
    parameter int DEF_DIV  = B19200_100M_DIV,
    parameter int DEF_FRAC = B19200_100M_FRAC
) (
    input  logic           clk,
    input  logic           reset,
    baud_frac_gen_if.slave bus
);

    localparam int OVS_W = ovs_width(OVS);
    localparam int DW1   = DIV_W + 1;

    logic [DIV_W-1:0]  act_int, shd_int, q;
    logic [FRAC_W-1:0] act_frac, shd_frac, acc;
    logic              c, pending;
    logic [DW1-1:0]    d_eff, last;
    logic [FRAC_W:0]   sum;
    logic              period_end, s_tick, apply, wrap;
    logic [OVS_W-1:0]  phase;

    // Ticks depend only on registered state and en/resync, never on div_* inputs
    always_comb begin
        d_eff      = (act_int == '0) ? DW1'(1) : {1'b0, act_int};
        last       = d_eff + DW1'(c) - DW1'(1);
        period_end = ({1'b0, q} == last);
        s_tick     = bus.en & ~bus.resync & period_end;
        apply      = pending & (s_tick | ~bus.en | bus.resync);
        sum        = {1'b0, acc} + {1'b0, act_frac};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q   <= '0;
            acc <= '0;
            c   <= 1'b0;
        end else if (bus.resync) begin
            q   <= '0;
            acc <= '0;
            c   <= 1'b0;
        end else if (bus.en) begin
            if (period_end) begin
                q   <= '0;
                acc <= sum[FRAC_W-1:0];
                c   <= sum[FRAC_W];
            end else begin
                q   <= q + DIV_W'(1);
            end
        end
    end

    // Swapping only at a period boundary keeps the running period intact
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_int  <= DIV_W'(DEF_DIV);
            act_frac <= FRAC_W'(DEF_FRAC);
            shd_int  <= DIV_W'(DEF_DIV);
            shd_frac <= FRAC_W'(DEF_FRAC);
            pending  <= 1'b0;
        end else begin
            if (apply) begin
                act_int  <= shd_int;
                act_frac <= shd_frac;
            end
            if (bus.div_load) begin
                shd_int  <= bus.div_int;
                shd_frac <= bus.div_frac;
                pending  <= 1'b1;
            end else if (apply) begin
                pending  <= 1'b0;
            end
        end
    end

    baud_ovs_counter #(.OVS(OVS)) u_ovs (
        .clk   (clk),
        .reset (reset),
        .clear (bus.resync),
        .inc   (s_tick),
        .wrap  (wrap),
        .phase (phase)
    );

    assign bus.s_tick   = s_tick;
    assign bus.bit_tick = wrap;
    assign bus.div_ack  = apply;
    assign bus.q        = q;
    assign bus.ovs_q    = phase;

endmodule

// File: tb/tb_baud_frac_gen.sv
// tb/tb_baud_frac_gen.sv - directed scoreboard bench for baud_frac_gen
module tb_baud_frac_gen;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        int   gap;
        logic bt;
        logic ack;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    baud_frac_gen_if #(.DIV_W(16), .FRAC_W(4), .OVS(16)) bif ();

    baud_frac_gen #(
        .DIV_W(16), .FRAC_W(4), .OVS(16), .DEF_DIV(325), .DEF_FRAC(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int gap, input logic bt, input logic ack);
        exp_t e;
        e.gap = gap;
        e.bt  = bt;
        e.ack = ack;
        sb.push_back(e);
    endtask

    // Counts cycles up to and including the next s_tick, starting in the current cycle
    task automatic wait_tick(input int budget, output int n, output logic bt, output logic ack, output logic got);
        n   = 0;
        bt  = 1'b0;
        ack = 1'b0;
        got = 1'b0;
        while (!got && n < budget) begin
            @(negedge clk);
            n++;
            if (bif.s_tick) begin
                got = 1'b1;
                bt  = bif.bit_tick;
                ack = bif.div_ack;
            end
            cyc();
        end
    endtask

    task automatic drain(input string tag, output int sum);
        exp_t e;
        int   n;
        logic bt, ack, got;
        sum = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_tick(400, n, bt, ack, got);
            chk({tag, "_tick_seen"}, 32'(got), 32'd1);
            chk({tag, "_gap"}, n, e.gap);
            chk({tag, "_bit_tick"}, 32'(bt), 32'(e.bt));
            chk({tag, "_div_ack"}, 32'(ack), 32'(e.ack));
            sum += n;
        end
    endtask

    task automatic load_quiet(input logic [15:0] di, input logic [3:0] df);
        bif.en       = 1'b0;
        bif.div_int  = di;
        bif.div_frac = df;
        bif.div_load = 1'b1;
        cyc();
        bif.div_load = 1'b0;
        bif.resync   = 1'b1;
        cyc();
        bif.resync   = 1'b0;
        bif.en       = 1'b1;
    endtask

    initial begin
        int   sum, acc_m, c_m, s;
        reset        = 1'b1;
        bif.en       = 1'b0;
        bif.resync   = 1'b0;
        bif.div_load = 1'b0;
        bif.div_int  = '0;
        bif.div_frac = '0;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_q", 32'(bif.q), 0);
        chk("rst_ovs_q", 32'(bif.ovs_q), 0);
        chk("rst_s_tick", 32'(bif.s_tick), 0);
        chk("rst_bit_tick", 32'(bif.bit_tick), 0);
        chk("rst_div_ack", 32'(bif.div_ack), 0);
        cyc();
        reset = 1'b0;

        // 10/0 loaded while idle: ack lands on the following clock
        bif.div_int  = 16'd10;
        bif.div_frac = 4'd0;
        bif.div_load = 1'b1;
        @(negedge clk);
        chk("load_cycle_ack", 32'(bif.div_ack), 0);
        cyc();
        bif.div_load = 1'b0;
        @(negedge clk);
        chk("idle_apply_ack", 32'(bif.div_ack), 1);
        cyc();

        bif.en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("walk_q", 32'(bif.q), i);
            chk("walk_s_tick", 32'(bif.s_tick), (i == 9) ? 1 : 0);
            cyc();
        end
        @(negedge clk);
        chk("walk_ovs_q", 32'(bif.ovs_q), 1);
        cyc();
        push(9, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) push(10, (i == 13), 1'b0);
        drain("div10", sum);

        // 10/8: carry model of the fractional accumulator
        bif.en       = 1'b0;
        bif.div_int  = 16'd10;
        bif.div_frac = 4'd8;
        bif.div_load = 1'b1;
        cyc();
        bif.div_load = 1'b0;
        bif.resync   = 1'b1;
        @(negedge clk);
        chk("resync_apply_ack", 32'(bif.div_ack), 1);
        cyc();
        bif.resync = 1'b0;
        bif.en     = 1'b1;
        acc_m = 0;
        c_m   = 0;
        for (int t = 0; t < 33; t++) begin
            push(10 + c_m, ((t % 16) == 15), 1'b0);
            s     = acc_m + 8;
            acc_m = s % 16;
            c_m   = s / 16;
            if (t == 0) drain("frac_first", sum);
        end
        drain("frac", sum);
        chk("frac_32_periods", sum, 336);

        // en dropped for 5 cycles at q=4
        load_quiet(16'd10, 4'd0);
        repeat (4) cyc();
        bif.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_q", 32'(bif.q), 4);
            chk("hold_s_tick", 32'(bif.s_tick), 0);
            cyc();
        end
        bif.en = 1'b1;
        push(6, 1'b0, 1'b0);
        drain("reenable", sum);

        // 20/0 loaded at q=3 takes effect after the current period
        repeat (3) cyc();
        bif.div_int  = 16'd20;
        bif.div_frac = 4'd0;
        bif.div_load = 1'b1;
        @(negedge clk);
        chk("mid_load_q", 32'(bif.q), 3);
        chk("mid_load_ack", 32'(bif.div_ack), 0);
        cyc();
        bif.div_load = 1'b0;
        push(6, 1'b0, 1'b1);
        push(20, 1'b0, 1'b0);
        push(20, 1'b0, 1'b0);
        drain("div20", sum);

        // resync at q=7, ovs_q=9
        load_quiet(16'd10, 4'd0);
        for (int i = 0; i < 9; i++) push(10, 1'b0, 1'b0);
        drain("pre_resync", sum);
        repeat (7) cyc();
        bif.resync = 1'b1;
        @(negedge clk);
        chk("pre_resync_q", 32'(bif.q), 7);
        chk("pre_resync_ovs", 32'(bif.ovs_q), 9);
        chk("resync_s_tick", 32'(bif.s_tick), 0);
        cyc();
        bif.resync = 1'b0;
        @(negedge clk);
        chk("post_resync_q", 32'(bif.q), 0);
        chk("post_resync_ovs", 32'(bif.ovs_q), 0);
        cyc();
        push(9, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) push(10, (i == 14), 1'b0);
        drain("post_resync", sum);

        // div_int=0 behaves as 1: tick every cycle
        load_quiet(16'd0, 4'd0);
        for (int i = 0; i < 3; i++) push(1, 1'b0, 1'b0);
        drain("div0", sum);
        bif.resync = 1'b1;
        @(negedge clk);
        chk("resync_prio_s_tick", 32'(bif.s_tick), 0);
        cyc();
        bif.resync   = 1'b0;
        bif.div_int  = 16'd5;
        bif.div_load = 1'b1;
        @(negedge clk);
        chk("coinc_first_tick", 32'(bif.s_tick), 1);
        chk("coinc_first_ack", 32'(bif.div_ack), 0);
        cyc();
        bif.div_int = 16'd7;
        @(negedge clk);
        chk("coinc_apply_tick", 32'(bif.s_tick), 1);
        chk("coinc_apply_ack", 32'(bif.div_ack), 1);
        cyc();
        bif.div_load = 1'b0;
        push(5, 1'b0, 1'b1);
        push(7, 1'b0, 1'b0);
        drain("coinc", sum);

        // reset mid-run with a load still pending
        cyc();
        bif.div_int  = 16'd3;
        bif.div_load = 1'b1;
        cyc();
        bif.div_load = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        chk("midrst_q", 32'(bif.q), 0);
        chk("midrst_ovs_q", 32'(bif.ovs_q), 0);
        chk("midrst_s_tick", 32'(bif.s_tick), 0);
        chk("midrst_bit_tick", 32'(bif.bit_tick), 0);
        chk("midrst_div_ack", 32'(bif.div_ack), 0);
        cyc();
        reset = 1'b0;
        push(325, 1'b0, 1'b0);
        push(325, 1'b0, 1'b0);
        push(326, 1'b0, 1'b0);
        drain("default_div", sum);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
